// File: rtl/mem_stage_if.sv
// Purpose: groups the exe-side request, memory bus and writeback signals of mem_stage.
// Latency: none (wires only).
// Backpressure: ex_ready / mem_gnt / mem_rvalid carried here; slave = mem_stage view, master = environment view.
interface mem_stage_if;
    // exe_stage -> mem_stage
    logic        ex_valid;
    logic        ex_ready;
    logic        ex_is_load;
    logic        ex_is_store;
    logic [1:0]  ex_size;
    logic        ex_unsigned;
    logic [63:0] ex_addr;
    logic [63:0] ex_wdata;
    logic [63:0] ex_rd_data;
    logic [4:0]  ex_rd_addr;
    logic        ex_rd_w_ena;

    // data memory bus
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;

    // writeback to regfile
    logic        wb_valid;
    logic [4:0]  wb_rd_addr;
    logic [63:0] wb_rd_data;
    logic        wb_rd_w_ena;
    logic        wb_misalign;

    modport slave (
        input  ex_valid, ex_is_load, ex_is_store, ex_size, ex_unsigned,
               ex_addr, ex_wdata, ex_rd_data, ex_rd_addr, ex_rd_w_ena,
               mem_gnt, mem_rvalid, mem_rdata,
        output ex_ready,
               mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
               wb_valid, wb_rd_addr, wb_rd_data, wb_rd_w_ena, wb_misalign
    );

    modport master (
        output ex_valid, ex_is_load, ex_is_store, ex_size, ex_unsigned,
               ex_addr, ex_wdata, ex_rd_data, ex_rd_addr, ex_rd_w_ena,
               mem_gnt, mem_rvalid, mem_rdata,
        input  ex_ready,
               mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
               wb_valid, wb_rd_addr, wb_rd_data, wb_rd_w_ena, wb_misalign
    );
endinterface

// File: rtl/mem_stage.sv
// Purpose: pipeline memory stage; issues one aligned 64-bit bus access per load/store, passes ALU results through.
// Latency: ALU op 1 cycle to wb_valid; store >= 2; load >= 3 (gnt/rvalid stalls add cycles).
// Backpressure: ex_ready only in IDLE, one access outstanding; optional MEM_MISALIGN_CHK_EN flags misaligned ops instead of issuing them.
module mem_stage (
    input  logic       clk,
    input  logic       rst,
    mem_stage_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;

    // operation context captured at acceptance, needed after the bus response
    logic        is_store_q;
    logic        unsigned_q;
    logic        rd_w_ena_q;
    logic [1:0]  size_q;
    logic [2:0]  addr_lo_q;
    logic [4:0]  rd_addr_q;

    logic        ex_mem_op;
    logic        ex_misalign;
    logic [7:0]  size_mask;
    logic [63:0] load_shift;
    logic [63:0] load_ext;

    assign ex_mem_op = bus.ex_is_load | bus.ex_is_store;

`ifdef MEM_MISALIGN_CHK_EN
    // an access is misaligned when any address bit below its size is set
    always_comb begin
        ex_misalign = 1'b0;
        if (ex_mem_op) begin
            case (bus.ex_size)
                2'b01:   ex_misalign = bus.ex_addr[0];
                2'b10:   ex_misalign = |bus.ex_addr[1:0];
                2'b11:   ex_misalign = |bus.ex_addr[2:0];
                default: ex_misalign = 1'b0;
            endcase
        end
    end
`else
    assign ex_misalign = 1'b0;
`endif

    // byte-lane mask for the access size, before lane shifting
    always_comb begin
        size_mask = 8'hFF;
        case (bus.ex_size)
            2'b00:   size_mask = 8'h01;
            2'b01:   size_mask = 8'h03;
            2'b10:   size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
    end

    // move the addressed lanes down to bit 0, then truncate and extend to the load size
    always_comb begin
        load_shift = bus.mem_rdata >> {addr_lo_q, 3'b000};
        load_ext   = load_shift;
        case (size_q)
            2'b00:   load_ext = unsigned_q ? {56'd0, load_shift[7:0]}
                                           : {{56{load_shift[7]}}, load_shift[7:0]};
            2'b01:   load_ext = unsigned_q ? {48'd0, load_shift[15:0]}
                                           : {{48{load_shift[15]}}, load_shift[15:0]};
            2'b10:   load_ext = unsigned_q ? {32'd0, load_shift[31:0]}
                                           : {{32{load_shift[31]}}, load_shift[31:0]};
            default: load_ext = load_shift;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next state and ready; ALU ops and flagged misaligned ops skip the bus
    always_comb begin
        state_nxt    = state;
        bus.ex_ready = 1'b0;
        case (state)
            IDLE: begin
                bus.ex_ready = 1'b1;
                if (bus.ex_valid) begin
                    state_nxt = (ex_mem_op && !ex_misalign) ? REQ : DONE;
                end
            end
            REQ: begin
                if (bus.mem_gnt) begin
                    state_nxt = is_store_q ? DONE : WAIT;
                end
            end
            WAIT: begin
                if (bus.mem_rvalid) begin
                    state_nxt = DONE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // registered bus request, writeback result and captured op context
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.mem_req     <= 1'b0;
            bus.mem_we      <= 1'b0;
            bus.mem_addr    <= '0;
            bus.mem_wdata   <= '0;
            bus.mem_wmask   <= '0;
            bus.wb_valid    <= 1'b0;
            bus.wb_rd_addr  <= '0;
            bus.wb_rd_data  <= '0;
            bus.wb_rd_w_ena <= 1'b0;
            bus.wb_misalign <= 1'b0;
            is_store_q      <= 1'b0;
            unsigned_q      <= 1'b0;
            rd_w_ena_q      <= 1'b0;
            size_q          <= '0;
            addr_lo_q       <= '0;
            rd_addr_q       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.ex_valid) begin
                        is_store_q <= bus.ex_is_store;
                        unsigned_q <= bus.ex_unsigned;
                        rd_w_ena_q <= bus.ex_rd_w_ena;
                        size_q     <= bus.ex_size;
                        addr_lo_q  <= bus.ex_addr[2:0];
                        rd_addr_q  <= bus.ex_rd_addr;
                        if (ex_mem_op && !ex_misalign) begin
                            bus.mem_req   <= 1'b1;
                            bus.mem_we    <= bus.ex_is_store;
                            bus.mem_addr  <= {bus.ex_addr[63:3], 3'b000};
                            bus.mem_wmask <= size_mask << bus.ex_addr[2:0];
                            bus.mem_wdata <= bus.ex_wdata << {bus.ex_addr[2:0], 3'b000};
                        end else begin
                            bus.wb_valid    <= 1'b1;
                            bus.wb_rd_addr  <= bus.ex_rd_addr;
                            bus.wb_rd_data  <= ex_misalign ? 64'd0 : bus.ex_rd_data;
                            bus.wb_rd_w_ena <= !ex_misalign && bus.ex_rd_w_ena
                                               && (bus.ex_rd_addr != 5'd0);
                            bus.wb_misalign <= ex_misalign;
                        end
                    end
                end
                REQ: begin
                    if (bus.mem_gnt) begin
                        bus.mem_req <= 1'b0;
                        if (is_store_q) begin
                            bus.wb_valid    <= 1'b1;
                            bus.wb_rd_addr  <= rd_addr_q;
                            bus.wb_rd_data  <= '0;
                            bus.wb_rd_w_ena <= 1'b0;
                        end
                    end
                end
                WAIT: begin
                    if (bus.mem_rvalid) begin
                        bus.wb_valid    <= 1'b1;
                        bus.wb_rd_addr  <= rd_addr_q;
                        bus.wb_rd_data  <= load_ext;
                        bus.wb_rd_w_ena <= rd_w_ena_q && (rd_addr_q != 5'd0);
                    end
                end
                default: begin
                    // writeback lasts one cycle; drop enables so the regfile cannot double-write
                    bus.wb_valid    <= 1'b0;
                    bus.wb_rd_w_ena <= 1'b0;
                    bus.wb_misalign <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Purpose: directed self-checking bench for mem_stage with a writeback scoreboard.
// Latency: checks 1/2/3-cycle minimum latencies and stalled accesses.
// Backpressure: drives mem_gnt/mem_rvalid stalls and holds ex_valid while ex_ready is low.
module tb_mem_stage;

    logic clk;
    logic rst;

    mem_stage_if bus ();

    mem_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [63:0] data;
        logic        w_ena;
        logic        mis;
        bit          chk_data;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic set_ex(input logic ld, input logic st, input logic [1:0] size, input logic uns,
                          input logic [63:0] addr, input logic [63:0] wdata, input logic [63:0] rdd,
                          input logic [4:0] rd, input logic wen);
        bus.ex_is_load  = ld;
        bus.ex_is_store = st;
        bus.ex_size     = size;
        bus.ex_unsigned = uns;
        bus.ex_addr     = addr;
        bus.ex_wdata    = wdata;
        bus.ex_rd_data  = rdd;
        bus.ex_rd_addr  = rd;
        bus.ex_rd_w_ena = wen;
        bus.ex_valid    = 1'b1;
    endtask

    task automatic push_exp(input logic [4:0] rd, input logic [63:0] data, input logic w_ena,
                            input logic mis, input bit chk_data);
        exp_t e;
        e.rd = rd; e.data = data; e.w_ena = w_ena; e.mis = mis; e.chk_data = chk_data;
        sb_q.push_back(e);
    endtask

    // wait (bounded) for a writeback pulse, compare it with the scoreboard head, confirm it is one cycle
    task automatic wait_wb(input string tag);
        exp_t e;
        int   n = 0;
        while (bus.wb_valid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check({tag, "_wb_vld"}, bus.wb_valid, 1);
        check({tag, "_sb_depth"}, sb_q.size(), 1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (bus.wb_valid === 1'b1) begin
                check({tag, "_rd_addr"}, bus.wb_rd_addr, e.rd);
                check({tag, "_w_ena"}, bus.wb_rd_w_ena, e.w_ena);
                check({tag, "_misalign"}, bus.wb_misalign, e.mis);
                if (e.chk_data) check({tag, "_rd_data"}, bus.wb_rd_data, e.data);
            end
        end
        step();
        check({tag, "_wb_pulse"}, bus.wb_valid, 0);
    endtask

    task automatic do_load(input string tag, input logic [63:0] addr, input logic [1:0] size,
                           input logic uns, input logic [4:0] rd, input logic [63:0] rdata,
                           input logic [63:0] exp_addr, input logic [7:0] exp_mask,
                           input logic [63:0] exp_data);
        set_ex(1'b1, 1'b0, size, uns, addr, 64'h0, 64'hDEAD, rd, 1'b1);
        push_exp(rd, exp_data, rd != 5'd0, 1'b0, 1'b1);
        step();
        bus.ex_valid = 1'b0;
        check({tag, "_req"}, bus.mem_req, 1);
        check({tag, "_addr"}, bus.mem_addr, exp_addr);
        check({tag, "_mask"}, bus.mem_wmask, exp_mask);
        check({tag, "_we"}, bus.mem_we, 0);
        bus.mem_gnt = 1'b1;
        step();
        bus.mem_gnt = 1'b0;
        check({tag, "_req_drop"}, bus.mem_req, 0);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = rdata;
        step();
        bus.mem_rvalid = 1'b0;
        check({tag, "_lat3"}, bus.wb_valid, 1);
        wait_wb(tag);
    endtask

    task automatic do_store(input string tag, input logic [63:0] addr, input logic [1:0] size,
                            input logic [63:0] wdata, input logic [4:0] rd,
                            input logic [63:0] exp_addr, input logic [7:0] exp_mask,
                            input logic [63:0] exp_wdata);
        set_ex(1'b0, 1'b1, size, 1'b0, addr, wdata, 64'h0, rd, 1'b1);
        push_exp(rd, 64'h0, 1'b0, 1'b0, 1'b0);
        step();
        bus.ex_valid = 1'b0;
        check({tag, "_req"}, bus.mem_req, 1);
        check({tag, "_addr"}, bus.mem_addr, exp_addr);
        check({tag, "_mask"}, bus.mem_wmask, exp_mask);
        check({tag, "_wdata"}, bus.mem_wdata, exp_wdata);
        check({tag, "_we"}, bus.mem_we, 1);
        bus.mem_gnt = 1'b1;
        step();
        bus.mem_gnt = 1'b0;
        check({tag, "_lat2"}, bus.wb_valid, 1);
        wait_wb(tag);
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_ex_ready"}, bus.ex_ready, 1);
        check({tag, "_mem_req"}, bus.mem_req, 0);
        check({tag, "_mem_we"}, bus.mem_we, 0);
        check({tag, "_mem_addr"}, bus.mem_addr, 0);
        check({tag, "_mem_wdata"}, bus.mem_wdata, 0);
        check({tag, "_mem_wmask"}, bus.mem_wmask, 0);
        check({tag, "_wb_valid"}, bus.wb_valid, 0);
        check({tag, "_wb_rd_addr"}, bus.wb_rd_addr, 0);
        check({tag, "_wb_rd_data"}, bus.wb_rd_data, 0);
        check({tag, "_wb_rd_w_ena"}, bus.wb_rd_w_ena, 0);
        check({tag, "_wb_misalign"}, bus.wb_misalign, 0);
    endtask

    initial begin
        rst            = 1'b1;
        bus.ex_valid   = 1'b0;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 64'h0;
        set_ex(1'b0, 1'b0, 2'b00, 1'b0, 64'h0, 64'h0, 64'h0, 5'd0, 1'b0);
        bus.ex_valid   = 1'b0;

        // reset state
        step();
        step();
        rst = 1'b0;
        check_idle_zero("reset");

        // ALU pass-through, latency 1
        set_ex(1'b0, 1'b0, 2'b11, 1'b0, 64'h0, 64'h0, 64'h1234, 5'd5, 1'b1);
        push_exp(5'd5, 64'h1234, 1'b1, 1'b0, 1'b1);
        step();
        bus.ex_valid = 1'b0;
        check("alu_lat1", bus.wb_valid, 1);
        check("alu_busy", bus.ex_ready, 0);
        wait_wb("alu");

        // ALU write to x0 never enables the regfile
        set_ex(1'b0, 1'b0, 2'b11, 1'b0, 64'h0, 64'h0, 64'hCAFE, 5'd0, 1'b1);
        push_exp(5'd0, 64'hCAFE, 1'b0, 1'b0, 1'b1);
        step();
        bus.ex_valid = 1'b0;
        wait_wb("alu_x0");

        // byte loads, signed and unsigned
        do_load("lb_s", 64'h1003, 2'b00, 1'b0, 5'd7, 64'h0000_0000_8000_0000,
                64'h1000, 8'h08, 64'hFFFF_FFFF_FFFF_FF80);
        do_load("lb_u", 64'h1003, 2'b00, 1'b1, 5'd7, 64'h0000_0000_8000_0000,
                64'h1000, 8'h08, 64'h0000_0000_0000_0080);

        // half loads from the top lanes
        do_load("lh_s", 64'h5006, 2'b01, 1'b0, 5'd8, 64'hABCD_0000_0000_0000,
                64'h5000, 8'hC0, 64'hFFFF_FFFF_FFFF_ABCD);
        do_load("lh_u", 64'h5006, 2'b01, 1'b1, 5'd8, 64'hABCD_0000_0000_0000,
                64'h5000, 8'hC0, 64'h0000_0000_0000_ABCD);

        // half store
        do_store("sh", 64'h2002, 2'b01, 64'hBEEF, 5'd6, 64'h2000, 8'h0C, 64'h0000_0000_BEEF_0000);

        // word load with grant and response stalls; ex inputs wiggle while busy
        set_ex(1'b1, 1'b0, 2'b10, 1'b0, 64'h3004, 64'h0, 64'h0, 5'd9, 1'b1);
        push_exp(5'd9, 64'hFFFF_FFFF_8765_4321, 1'b1, 1'b0, 1'b1);
        step();
        bus.ex_addr     = 64'hFFFF_0000;
        bus.ex_is_store = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("stall_gnt_req", bus.mem_req, 1);
            check("stall_gnt_addr", bus.mem_addr, 64'h3000);
            check("stall_gnt_mask", bus.mem_wmask, 8'hF0);
            check("stall_gnt_we", bus.mem_we, 0);
            check("stall_gnt_ready", bus.ex_ready, 0);
            check("stall_gnt_wb", bus.wb_valid, 0);
            step();
        end
        bus.ex_valid    = 1'b0;
        bus.ex_is_store = 1'b0;
        bus.mem_gnt     = 1'b1;
        step();
        bus.mem_gnt = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("stall_rv_req", bus.mem_req, 0);
            check("stall_rv_ready", bus.ex_ready, 0);
            check("stall_rv_wb", bus.wb_valid, 0);
            step();
        end
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 64'h8765_4321_0000_0000;
        step();
        bus.mem_rvalid = 1'b0;
        wait_wb("stall_lw");

        // reset while waiting for the read response abandons the access
        set_ex(1'b1, 1'b0, 2'b10, 1'b0, 64'h4000, 64'h0, 64'h0, 5'd3, 1'b1);
        step();
        bus.ex_valid = 1'b0;
        bus.mem_gnt  = 1'b1;
        step();
        bus.mem_gnt = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_idle_zero("mid_rst");
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 64'h1111_2222_3333_4444;
        step();
        bus.mem_rvalid = 1'b0;
        check("mid_rst_no_wb0", bus.wb_valid, 0);
        step();
        check("mid_rst_no_wb1", bus.wb_valid, 0);
        check("mid_rst_ready", bus.ex_ready, 1);

`ifdef MEM_MISALIGN_CHK_EN
        // misaligned word load is flagged without touching the bus
        set_ex(1'b1, 1'b0, 2'b10, 1'b0, 64'h1002, 64'h0, 64'h0, 5'd4, 1'b1);
        push_exp(5'd4, 64'h0, 1'b0, 1'b1, 1'b0);
        step();
        bus.ex_valid = 1'b0;
        check("mis_no_req", bus.mem_req, 0);
        wait_wb("mis_lw");
        check("mis_after_req", bus.mem_req, 0);
`else
        // misaligned accesses go out as-is, lanes past bit 63 dropped
        do_load("una_lw", 64'h1002, 2'b10, 1'b0, 5'd4, 64'h0000_8899_AABB_0000,
                64'h1000, 8'h3C, 64'hFFFF_FFFF_8899_AABB);
        do_store("una_sd", 64'h6005, 2'b11, 64'h1122_3344_5566_7788, 5'd2,
                 64'h6000, 8'hE0, 64'h6677_8800_0000_0000);
`endif

        check("sb_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
